ps_bigreg_collector: RTL and testbench

- Sits directly downstream of the AXI-lite mem_map write port.
- Captures PS writes to one PS_BIGREG window: SAMPLES consecutive 16-bit entries starting at BASE_ID, plus the VALID entry at BASE_ID+SAMPLES.
- When the valid entry is written and every entry is fresh, it assembles one wide word and hands it to the RTL consumer (seed generator, channel mux, sample discriminator) over a valid/ready handshake.
- It returns an AXI response code for every write it claims.

---
 rtl/ps_bigreg_collector.sv | 167 ++++++++++++++++
 tb/tb_ps_bigreg_collector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ps_bigreg_collector.sv
// Collects one PS_BIGREG window (SAMPLES entries plus a VALID entry) from mem_map writes and emits it as one wide word.
// Optional idle timeout in COLLECT is enabled by defining BIGREG_TIMEOUT_EN.
module ps_bigreg_collector #(
  parameter int BASE_ID        = 1,
  parameter int SAMPLES        = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int ID_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_en,
  input  logic [ID_WIDTH-1:0]              wr_id,
  input  logic [31:0]                      wr_data,
  output logic                             resp_valid,
  output logic [1:0]                       resp,
  output logic [SAMPLES-1:0]               fresh_mask,
  output logic [SAMPLES*DATA_WIDTH-1:0]    out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy
);

  localparam int OFF_W = $clog2(SAMPLES + 1);
  localparam logic [ID_WIDTH-1:0] ID_LO = ID_WIDTH'(BASE_ID);
  localparam logic [ID_WIDTH-1:0] ID_HI = ID_WIDTH'(BASE_ID + SAMPLES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

  state_t                  state_reg, state_next;
  logic [SAMPLES-1:0]      fresh_reg, fresh_next;
  logic [DATA_WIDTH-1:0]   entry_reg [SAMPLES];
  logic [DATA_WIDTH-1:0]   word_reg  [SAMPLES];
  logic                    out_valid_reg, out_valid_next;
  logic                    resp_valid_reg;
  logic [1:0]              resp_reg, resp_next;
  logic                    claimed;
  logic                    is_valid_id;
  logic [OFF_W-1:0]        offset;
  logic                    store_en;
  logic                    emit;
  logic                    clear;
  logic                    timeout_hit;

  assign claimed     = wr_en && (wr_id >= ID_LO) && (wr_id <= ID_HI);
  assign offset      = OFF_W'(wr_id - ID_LO);
  assign is_valid_id = (offset == OFF_W'(SAMPLES));

  always_comb begin
    state_next     = state_reg;
    fresh_next     = fresh_reg;
    out_valid_next = out_valid_reg;
    resp_next      = RESP_OKAY;
    store_en       = 1'b0;
    emit           = 1'b0;
    clear          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (claimed) begin
          if (is_valid_id) begin
            resp_next = RESP_SLVERR;
          end else begin
            store_en   = 1'b1;
            fresh_next = fresh_reg | (SAMPLES'(1) << offset);
            state_next = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (claimed) begin
          if (!is_valid_id) begin
            store_en   = 1'b1;
            fresh_next = fresh_reg | (SAMPLES'(1) << offset);
          end else if (&fresh_reg) begin
            emit           = 1'b1;
            fresh_next     = '0;
            out_valid_next = 1'b1;
            state_next     = HOLD;
          end else begin
            resp_next = RESP_SLVERR;
          end
        end else if (timeout_hit) begin
          clear      = 1'b1;
          fresh_next = '0;
          state_next = IDLE;
        end
      end
      HOLD: begin
        // A write racing the handshake is still judged against HOLD.
        if (claimed) resp_next = RESP_SLVERR;
        if (out_valid_reg && out_ready) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      fresh_reg      <= '0;
      out_valid_reg  <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_reg       <= RESP_OKAY;
    end else begin
      state_reg      <= state_next;
      fresh_reg      <= fresh_next;
      out_valid_reg  <= out_valid_next;
      resp_valid_reg <= claimed;
      resp_reg       <= resp_next;
    end
  end

  for (genvar gi = 0; gi < SAMPLES; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
        entry_reg[gi] <= '0;
      end else if (store_en && offset == OFF_W'(gi)) begin
        entry_reg[gi] <= wr_data[DATA_WIDTH-1:0];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        word_reg[gi] <= '0;
      end else if (emit) begin
        word_reg[gi] <= entry_reg[gi];
      end
    end

    assign out_data[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg[gi];
  end

`ifdef BIGREG_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] idle_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || state_reg != COLLECT || claimed || timeout_hit) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + CNT_W'(1);
    end
  end

  assign timeout_hit = (state_reg == COLLECT) && !claimed &&
                       (idle_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  if (DATA_WIDTH < 32) begin : g_unused
    logic unused_hi;
    assign unused_hi = ^wr_data[31:DATA_WIDTH];
  end

  assign resp_valid = resp_valid_reg;
  assign resp       = resp_reg;
  assign fresh_mask = fresh_reg;
  assign out_valid  = out_valid_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_ps_bigreg_collector.sv
// Directed plus random bench for ps_bigreg_collector against a window-level reference model.
module tb_ps_bigreg_collector;
  localparam int BASE = 1;
  localparam int N    = 16;
  localparam int DW   = 16;
  localparam int IDW  = 8;
`ifdef BIGREG_TIMEOUT_EN
  localparam int TO    = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 1024;
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_en;
  logic [IDW-1:0]  wr_id;
  logic [31:0]     wr_data;
  logic            resp_valid;
  logic [1:0]      resp;
  logic [N-1:0]    fresh_mask;
  logic [N*DW-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  ps_bigreg_collector #(
    .BASE_ID(BASE), .SAMPLES(N), .DATA_WIDTH(DW), .ID_WIDTH(IDW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
    .resp_valid(resp_valid), .resp(resp), .fresh_mask(fresh_mask),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: entry values, which entries are fresh, and the word held for the consumer.
  logic [DW-1:0]   m_stor [N];
  logic [N-1:0]    m_fresh;
  bit              m_hold;
  logic [N*DW-1:0] m_word;
  int              m_idle;

  task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_stor[i] = '0;
    m_fresh = '0;
    m_hold  = 1'b0;
    m_word  = '0;
    m_idle  = 0;
  endtask

  task automatic step(bit rst, bit en, int id, logic [15:0] data, bit ready, string tag);
    bit         exp_rv;
    logic [1:0] exp_resp;
    bit         claimed;
    int         off;
    rst_n     = !rst;
    wr_en     = en;
    wr_id     = IDW'(id);
    wr_data   = {16'($urandom), data};
    out_ready = ready;
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    claimed  = en && id >= BASE && id <= BASE + N;
    exp_rv   = claimed;
    exp_resp = 2'b00;
    if (rst) begin
      model_reset();
      exp_rv = 1'b0;
    end else if (m_hold) begin
      if (claimed) exp_resp = 2'b10;
      if (ready) m_hold = 1'b0;
    end else if (claimed) begin
      off    = id - BASE;
      m_idle = 0;
      if (off < N) begin
        m_stor[off]  = data;
        m_fresh[off] = 1'b1;
      end else if (m_fresh == {N{1'b1}}) begin
        for (int i = 0; i < N; i++) m_word[i*DW +: DW] = m_stor[i];
        m_hold  = 1'b1;
        m_fresh = '0;
      end else begin
        exp_resp = 2'b10;
      end
    end else if (m_fresh != 0) begin
      m_idle++;
      if (TO_EN && m_idle == TO) begin
        m_fresh = '0;
        for (int i = 0; i < N; i++) m_stor[i] = '0;
        m_idle = 0;
      end
    end
    chk({tag, ".resp_valid"}, 256'(resp_valid), 256'(exp_rv));
    if (exp_rv) chk({tag, ".resp"}, 256'(resp), 256'(exp_resp));
    chk({tag, ".out_valid"}, 256'(out_valid), 256'(m_hold));
    chk({tag, ".mask"}, 256'(fresh_mask), 256'(m_fresh));
    chk({tag, ".busy"}, 256'(busy), 256'(m_hold || m_fresh != 0));
    chk({tag, ".data"}, 256'(out_data), 256'(m_word));
    $display("[TB] %s rst=%0b en=%0b id=%0d ready=%0b rv=%0b resp=%0b ov=%0b mask=%h",
             tag, rst, en, id, ready, resp_valid, resp, out_valid, fresh_mask);
  endtask

  task automatic fill(string tag);
    for (int id = 1; id <= N; id++) step(0, 1, id, 16'($urandom), 1'b0, tag);
  endtask

  logic [N*DW-1:0] held;

  initial begin
    model_reset();
    rst_n = 1'b0; wr_en = 1'b0; wr_id = '0; wr_data = '0; out_ready = 1'b0;
    step(1, 0, 0, 16'h0, 0, "reset");
    step(1, 0, 0, 16'h0, 0, "reset");

    for (int id = 1; id <= N; id++) step(0, 1, id, 16'(16'h1000 + id - 1), 1, "full");
    step(0, 1, N + 1, 16'hDEAD, 1, "full_valid");
    chk("full_lo", 256'(out_data[15:0]), 256'(16'h1000));
    chk("full_hi", 256'(out_data[255:240]), 256'(16'h100F));
    step(0, 0, 0, 16'h0, 1, "full_hs");
    step(0, 0, 0, 16'h0, 1, "full_idle");

    for (int id = 1; id < N; id++) step(0, 1, id, 16'(16'h2000 + id), 0, "early");
    step(0, 1, N + 1, 16'h0, 0, "early_valid");
    chk("early_mask", 256'(fresh_mask), 256'(16'h7FFF));
    step(0, 1, N, 16'h2FFF, 0, "early_last");
    step(0, 1, N + 1, 16'h0, 1, "early_emit");
    step(0, 0, 0, 16'h0, 1, "early_hs");

    for (int id = N; id >= 1; id--) begin
      if (id == 5) step(0, 1, 5, 16'hAAAA, 0, "ovr");
      step(0, 1, id, (id == 5) ? 16'h5555 : 16'(16'h3000 + id), 0, "ovr");
    end
    step(0, 1, N + 1, 16'h0, 0, "ovr_valid");
    chk("ovr_entry4", 256'(out_data[79:64]), 256'(16'h5555));
    step(0, 0, 0, 16'h0, 1, "ovr_hs");

    fill("bp_fill");
    step(0, 1, N + 1, 16'h0, 0, "bp_valid");
    held = out_data;
    for (int k = 0; k < 10; k++) begin
      if (k == 3)      step(0, 1, 3, 16'hBEEF, 0, "bp_wr3");
      else if (k == 6) step(0, 1, N + 1, 16'h0, 0, "bp_wr17");
      else             step(0, 0, 0, 16'h0, 0, "bp_wait");
      chk("bp_stable", 256'(out_data), 256'(held));
    end
    step(0, 0, 0, 16'h0, 1, "bp_hs");
    step(0, 0, 0, 16'h0, 1, "bp_idle");

    fill("rh_fill");
    step(0, 1, N + 1, 16'h0, 0, "rh_valid");
    step(1, 0, 0, 16'h0, 0, "rh_reset");
    step(0, 1, 0, 16'h1111, 0, "unclaimed0");
    step(0, 1, N + 2, 16'h2222, 0, "unclaimed18");

    step(0, 1, 1, 16'h1234, 0, "to_write");
    for (int k = 0; k < 8; k++) step(0, 0, 0, 16'h0, 0, "to_idle");
    chk("to_mask", 256'(fresh_mask), TO_EN ? 256'(0) : 256'(16'h0001));
    step(1, 0, 0, 16'h0, 0, "to_reset");

    for (int k = 0; k < 400; k++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step(r == 0, r < 75, int'($urandom_range(0, N + 2)), 16'($urandom),
           bit'($urandom_range(0, 1)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
